vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; successor to the fixed 640x480 sync generator. Produces h_sync/v_sync with configurable porch, sync widths and polarities, plus data-enable, pixel coordinates and frame/line strobes for the pixel pipeline. Advances only on a pixel-clock enable, so one fast system clock can drive any pixel rate. Sits between the clock/enable generator and the framebuffer read/pixel pipeline.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/timing_axis.sv | 54 +++++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing presets for the VGA timing generator and a helper that
// sizes a counter for a given axis total.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel rate
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam logic VGA640_H_POL  = 1'b0;
  localparam logic VGA640_V_POL  = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel rate, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam logic SVGA800_H_POL  = 1'b1;
  localparam logic SVGA800_V_POL  = 1'b1;

  // Bits needed to hold the values 0..total-1.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping position counter with active-area flag and a
// polarised, not yet registered, sync level.
module timing_axis #(
  parameter int   CW     = 12,
  parameter int   TOTAL  = 800,
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter logic POL    = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o,
  output logic          active_o,
  output logic          sync_raw_o
);

  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // clear beats enable so a restart never also advances
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CW{1'b0}};
    end else if (en_i) begin
      count_d = wrap_o ? {CW{1'b0}} : count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  assign count_o    = count_q;
  assign wrap_o     = (count_q == LAST);
  assign active_o   = (count_q < ACT_END);
  assign sync_raw_o = ((count_q >= SYNC_BEG) && (count_q < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advancing on a pixel enable; all
// outputs come from one register stage one enabled tick behind the counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CW         = 12,
  parameter int   H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int   H_FP       = VGA640_H_FP,
  parameter int   H_SYNC     = VGA640_H_SYNC,
  parameter int   H_BP       = VGA640_H_BP,
  parameter int   V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int   V_FP       = VGA640_V_FP,
  parameter int   V_SYNC     = VGA640_V_SYNC,
  parameter int   V_BP       = VGA640_V_BP,
  parameter logic H_SYNC_POL = VGA640_H_POL,
  parameter logic V_SYNC_POL = VGA640_V_POL
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          clear,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((cnt_width(H_TOTAL) > CW) || (cnt_width(V_TOTAL) > CW) ||
      (H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_params
    $error("vga_timing_gen: timing totals exceed counter width or a porch/sync is zero");
  end

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, h_active, h_sync_raw;
  logic          v_wrap_unused, v_active, v_sync_raw;

  timing_axis #(
    .CW(CW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .POL(H_SYNC_POL)
  ) u_h_axis (
    .clk_i(ck), .rst_i(reset), .en_i(pix_en), .clear_i(clear),
    .count_o(h_cnt), .wrap_o(h_wrap), .active_o(h_active), .sync_raw_o(h_sync_raw)
  );

  // line counter steps on the same tick the pixel counter wraps
  timing_axis #(
    .CW(CW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .POL(V_SYNC_POL)
  ) u_v_axis (
    .clk_i(ck), .rst_i(reset), .en_i(pix_en && h_wrap), .clear_i(clear),
    .count_o(v_cnt), .wrap_o(v_wrap_unused), .active_o(v_active), .sync_raw_o(v_sync_raw)
  );

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          de_q, de_d, h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      x_q           <= {CW{1'b0}};
      y_q           <= {CW{1'b0}};
      de_q          <= 1'b0;
      h_sync_q      <= ~H_SYNC_POL;
      v_sync_q      <= ~V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // strobes default low so they last one ck even when pix_en is held high
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (clear) begin
      x_d      = {CW{1'b0}};
      y_d      = {CW{1'b0}};
      de_d     = 1'b0;
      h_sync_d = ~H_SYNC_POL;
      v_sync_d = ~V_SYNC_POL;
    end else if (pix_en) begin
      x_d           = h_cnt;
      y_d           = v_cnt;
      de_d          = h_active && v_active;
      h_sync_d      = h_sync_raw;
      v_sync_d      = v_sync_raw;
      line_start_d  = (h_cnt == {CW{1'b0}});
      frame_start_d = (h_cnt == {CW{1'b0}}) && (v_cnt == {CW{1'b0}});
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a tiny
// 4x2 instance, each compared tick by tick against a queued reference model.
module tb_vga_timing_gen;

  localparam int CW = 12;
  typedef logic [28:0] out_t;   // {hs, vs, de, x, y, ls, fs}

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rst = 1'b0;
  logic pe_a = 1'b0, clr_a = 1'b0, pe_b = 1'b0, clr_b = 1'b0;
  logic hs_a, vs_a, de_a, ls_a, fs_a, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [CW-1:0] x_a, y_a, x_b, y_b;

  vga_timing_gen dut_a (
    .ck(ck), .reset(rst), .pix_en(pe_a), .clear(clr_a),
    .h_sync(hs_a), .v_sync(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_b (
    .ck(ck), .reset(rst), .pix_en(pe_b), .clear(clr_b),
    .h_sync(hs_b), .v_sync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int checks = 0;
  int failures = 0;
  int nprint = 0;
  int cyc = 0;
  int sel = 0;
  int m_ha, m_hfp, m_hs, m_ht, m_va, m_vfp, m_vs, m_vt;
  logic m_pol;
  int m_h, m_v;
  out_t m_last;
  out_t exp_q[$];

  function automatic out_t pack(input logic hs, input logic vs, input logic de,
                                input logic [CW-1:0] xv, input logic [CW-1:0] yv,
                                input logic ls, input logic fs);
    return {hs, vs, de, xv, yv, ls, fs};
  endfunction

  function automatic out_t obs();
    if (sel == 0) return {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a};
    return {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b};
  endfunction

  function automatic out_t rst_val();
    return pack(~m_pol, ~m_pol, 1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0);
  endfunction

  task automatic select_dut(input int s);
    sel = s;
    if (s == 0) begin
      m_ha = 640; m_hfp = 16; m_hs = 96; m_ht = 800;
      m_va = 480; m_vfp = 10; m_vs = 2;  m_vt = 525; m_pol = 1'b0;
    end else begin
      m_ha = 4; m_hfp = 1; m_hs = 1; m_ht = 7;
      m_va = 2; m_vfp = 1; m_vs = 1; m_vt = 5; m_pol = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_last = rst_val();
    exp_q.delete();
  endtask

  task automatic do_reset();
    pe_a = 1'b0; clr_a = 1'b0; pe_b = 1'b0; clr_b = 1'b0;
    rst = 1'b1;
    @(posedge ck); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one ck of stimulus and queue what the outputs must be after it.
  task automatic tick(input logic en, input logic clr);
    out_t e;
    logic hs, vs, de;
    if (clr) begin
      m_h = 0; m_v = 0; e = rst_val();
    end else if (en) begin
      hs = (m_h >= m_ha + m_hfp && m_h < m_ha + m_hfp + m_hs) ? m_pol : ~m_pol;
      vs = (m_v >= m_va + m_vfp && m_v < m_va + m_vfp + m_vs) ? m_pol : ~m_pol;
      de = (m_h < m_ha) && (m_v < m_va);
      e = pack(hs, vs, de, CW'(m_h), CW'(m_v), m_h == 0, (m_h == 0) && (m_v == 0));
      if (m_h == m_ht - 1) begin
        m_h = 0;
        m_v = (m_v == m_vt - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end else begin
      e = {m_last[28:2], 2'b00};
    end
    m_last = e;
    exp_q.push_back(e);
    if (sel == 0) begin pe_a = en; clr_a = clr; end
    else begin pe_b = en; clr_b = clr; end
    @(posedge ck); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a} !== pack(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL reset_default got=%h exp=%h", {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a},
                           pack(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0));
    end
    checks++;
    if ({hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b} !== pack(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL reset_small got=%h exp=%h", {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b},
                           pack(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0));
    end
    @(posedge ck); #1;
    rst = 1'b0;
  endtask

  task automatic test_first_line();
    out_t e, o;
    int n_ls = 0, ls0 = 0, ls1 = 0, hs_low = 0, de_cnt = 0, fall_x = -1, n_fs = 0;
    logic hs_prev = 1'b1;
    select_dut(0); do_reset();
    for (int i = 0; i < 1700; i++) begin
      tick(1'b1, 1'b0);
      e = exp_q.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        if (nprint < 20) $display("FAIL first_line cyc=%0d got=%h exp=%h", cyc, o, e);
        nprint++;
      end
      if (ls_a) begin
        if (n_ls == 0) ls0 = cyc; else if (n_ls == 1) ls1 = cyc;
        n_ls++;
      end
      if (fs_a) n_fs++;
      if (n_ls == 1) begin
        if (!hs_a) hs_low++;
        if (de_a) de_cnt++;
        if (!hs_a && hs_prev) fall_x = int'(x_a);
      end
      hs_prev = hs_a;
    end
    checks++; if (ls1 - ls0 != 800) begin failures++; $display("FAIL line_period got=%0d exp=800", ls1 - ls0); end
    checks++; if (hs_low != 96) begin failures++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
    checks++; if (fall_x != 656) begin failures++; $display("FAIL hsync_start_x got=%0d exp=656", fall_x); end
    checks++; if (de_cnt != 640) begin failures++; $display("FAIL de_per_line got=%0d exp=640", de_cnt); end
    checks++; if (n_fs != 1) begin failures++; $display("FAIL frame_start_count got=%0d exp=1", n_fs); end
  endtask

  task automatic test_half_rate();
    out_t e, o;
    int n_ls = 0, ls0 = 0, ls1 = 0, wide = 0;
    logic ls_prev = 1'b0;
    select_dut(0); do_reset();
    for (int i = 0; i < 3300; i++) begin
      tick((i % 2) == 0, 1'b0);
      e = exp_q.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        if (nprint < 20) $display("FAIL half_rate cyc=%0d got=%h exp=%h", cyc, o, e);
        nprint++;
      end
      if (ls_a && ls_prev) wide++;
      if (ls_a) begin
        if (n_ls == 0) ls0 = cyc; else if (n_ls == 1) ls1 = cyc;
        n_ls++;
      end
      ls_prev = ls_a;
    end
    checks++; if (ls1 - ls0 != 1600) begin failures++; $display("FAIL half_rate_period got=%0d exp=1600", ls1 - ls0); end
    checks++; if (wide != 0) begin failures++; $display("FAIL strobe_width got=%0d wide exp=0", wide); end
    checks++; if (n_ls != 3) begin failures++; $display("FAIL half_rate_lines got=%0d exp=3", n_ls); end
  endtask

  task automatic test_async_reset(input int s, input int n);
    out_t e, o;
    select_dut(s); do_reset();
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0);
      e = exp_q.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        if (nprint < 20) $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, o, e);
        nprint++;
      end
    end
    #2 rst = 1'b1;
    #1;
    o = obs(); e = rst_val();
    checks++;
    if (o !== e) begin failures++; $display("FAIL async_reset dut=%0d got=%h exp=%h", s, o, e); end
    @(posedge ck); #1;
    rst = 1'b0;
    model_reset();
    tick(1'b1, 1'b0);
    e = exp_q.pop_front(); o = obs();
    checks++;
    if (o !== e) begin failures++; $display("FAIL restart dut=%0d got=%h exp=%h", s, o, e); end
    checks++;
    if (o[0] !== 1'b1) begin failures++; $display("FAIL restart_frame_start dut=%0d got=%b exp=1", s, o[0]); end
  endtask

  task automatic test_clear(input int s, input int n);
    out_t e, o;
    select_dut(s); do_reset();
    for (int i = 0; i < n + 2; i++) begin
      tick(1'b1, i == n);
      e = exp_q.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        if (nprint < 20) $display("FAIL clear_seq dut=%0d cyc=%0d got=%h exp=%h", s, cyc, o, e);
        nprint++;
      end
      if (i == n) begin
        checks++;
        if (o[28:2] !== {~m_pol, ~m_pol, 25'd0}) begin
          failures++; $display("FAIL clear_values dut=%0d got=%h exp=%h", s, o[28:2], {~m_pol, ~m_pol, 25'd0});
        end
      end
      if (i == n + 1) begin
        checks++;
        if (o[1:0] !== 2'b11) begin failures++; $display("FAIL clear_restart dut=%0d got=%b exp=11", s, o[1:0]); end
      end
    end
  endtask

  task automatic test_small_frame();
    out_t e, o;
    int xmax = 0, ymax = 0, hs_bad = 0, vs_bad = 0, wraps = 0, n_fs = 0, fs0 = 0, fs1 = 0, de_cnt = 0;
    logic [CW-1:0] px = '0, py = '0;
    select_dut(1); do_reset();
    for (int i = 0; i < 75; i++) begin
      tick(1'b1, 1'b0);
      e = exp_q.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        if (nprint < 20) $display("FAIL small_frame cyc=%0d got=%h exp=%h", cyc, o, e);
        nprint++;
      end
      if (int'(x_b) > xmax) xmax = int'(x_b);
      if (int'(y_b) > ymax) ymax = int'(y_b);
      if (hs_b !== (x_b == 12'd5)) hs_bad++;
      if (vs_b !== (y_b == 12'd3)) vs_bad++;
      if (px == 12'd6 && py == 12'd4 && x_b == 12'd0 && y_b == 12'd0) wraps++;
      if (fs_b) begin
        if (n_fs == 0) fs0 = cyc; else if (n_fs == 1) fs1 = cyc;
        n_fs++;
      end
      if (n_fs == 1 && de_b) de_cnt++;
      px = x_b; py = y_b;
    end
    checks++; if (xmax != 6) begin failures++; $display("FAIL small_xmax got=%0d exp=6", xmax); end
    checks++; if (ymax != 4) begin failures++; $display("FAIL small_ymax got=%0d exp=4", ymax); end
    checks++; if (hs_bad != 0) begin failures++; $display("FAIL small_hsync_pos got=%0d bad exp=0", hs_bad); end
    checks++; if (vs_bad != 0) begin failures++; $display("FAIL small_vsync_pos got=%0d bad exp=0", vs_bad); end
    checks++; if (wraps != 2) begin failures++; $display("FAIL small_wraps got=%0d exp=2", wraps); end
    checks++; if (fs1 - fs0 != 35) begin failures++; $display("FAIL small_frame_period got=%0d exp=35", fs1 - fs0); end
    checks++; if (de_cnt != 8) begin failures++; $display("FAIL small_de_count got=%0d exp=8", de_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_half_rate();
    test_async_reset(0, 701);
    test_clear(0, 101);
    test_small_frame();
    test_async_reset(1, 24);
    test_clear(1, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
